// File: rtl/array_seed_cell.sv
// Systolic BLAST seed-array comparison cell: holds one query nucleotide, forwards subjects with one
// cycle of latency and flags a seed hit when the diagonal match run reaches WORD_LEN.
// Optional feature macro: ARRAY_HIT_HOLD_EN (hit held until hit_ack, overrun reported on hit_drop).
`timescale 1ns/1ps

module array_seed_cell #(
   parameter int LENGTH_CHAR    = 3,
   parameter int LENGTH_COUNTER = 8,
   parameter int WORD_LEN       = 4,
   parameter int RUN_W          = 4
) (
   input  logic                      com_clk,
   input  logic                      reset,
   input  logic                      query_enable,
   input  logic [LENGTH_CHAR-1:0]    query_char_in,
   input  logic                      sub_enable,
   input  logic [LENGTH_CHAR-1:0]    sub_char_in,
   input  logic                      hit_ack,
   output logic [LENGTH_CHAR-1:0]    query_char_out,
   output logic [LENGTH_COUNTER-1:0] query_id,
   output logic [LENGTH_CHAR-1:0]    sub_char_out,
   output logic                      sub_valid_out,
   output logic [LENGTH_COUNTER-1:0] sub_id,
   output logic                      match,
   output logic [RUN_W-1:0]          run_len,
   output logic                      hit,
   output logic [LENGTH_COUNTER-1:0] hit_query_id,
   output logic [LENGTH_COUNTER-1:0] hit_sub_id,
   output logic                      hit_drop
);

   localparam logic [LENGTH_CHAR-1:0] CODE_A = LENGTH_CHAR'(1);
   localparam logic [LENGTH_CHAR-1:0] CODE_C = LENGTH_CHAR'(4);
   localparam logic [LENGTH_CHAR-1:0] CODE_N = LENGTH_CHAR'(5);

   typedef enum logic [1:0] {ST_EMPTY, ST_ARMED, ST_RUN} state_t;

   state_t                    state, state_nxt;
   logic [LENGTH_COUNTER-1:0] q_id, s_id;
   logic                      q_acc, s_acc, cmp_match, new_hit;
   logic [RUN_W-1:0]          run_nxt;
   logic [LENGTH_COUNTER-1:0] hit_sid_calc;

   // Query alphabet excludes N; the subject alphabet includes it (N streams through but never matches).
   always_comb begin
      q_acc     = query_enable && (query_char_in >= CODE_A) && (query_char_in <= CODE_C);
      s_acc     = sub_enable && (sub_char_in >= CODE_A) && (sub_char_in <= CODE_N);
      cmp_match = s_acc && (sub_char_in != CODE_N) && (query_char_out != '0) &&
                  (sub_char_in == query_char_out);
   end

   always_ff @(posedge com_clk) begin
      if (reset) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   // A query reload restarts the diagonal, so it wins over any subject compare this cycle.
   always_comb begin
      state_nxt = state;
      run_nxt   = run_len;
      new_hit   = 1'b0;
      if (q_acc) begin
         run_nxt   = '0;
         state_nxt = ST_ARMED;
      end else if (s_acc) begin
         if (cmp_match) begin
            run_nxt = (run_len == '1) ? run_len : run_len + RUN_W'(1);
            new_hit = (run_len == RUN_W'(WORD_LEN - 1));
            if (state == ST_ARMED) state_nxt = ST_RUN;
         end else begin
            run_nxt = '0;
            if (state == ST_RUN) state_nxt = ST_ARMED;
         end
      end
   end

   // Position of the first character of the word that just completed.
   assign hit_sid_calc = s_id + LENGTH_COUNTER'(1) - LENGTH_COUNTER'(WORD_LEN - 1);

   always_ff @(posedge com_clk) begin
      if (reset) begin
         query_char_out <= '0;
         query_id       <= '0;
         q_id           <= '1;
         sub_char_out   <= '0;
         sub_valid_out  <= 1'b0;
         sub_id         <= '0;
         s_id           <= '1;
         match          <= 1'b0;
         run_len        <= '0;
      end else begin
         if (q_acc) begin
            query_char_out <= query_char_in;
            q_id           <= q_id + LENGTH_COUNTER'(1);
            query_id       <= q_id + LENGTH_COUNTER'(1);
         end
         sub_valid_out <= s_acc;
         if (s_acc) begin
            sub_char_out <= sub_char_in;
            s_id         <= s_id + LENGTH_COUNTER'(1);
            sub_id       <= s_id + LENGTH_COUNTER'(1);
         end
         match   <= cmp_match;
         run_len <= run_nxt;
      end
   end

`ifdef ARRAY_HIT_HOLD_EN
   // Held hit: an unacknowledged pending hit blocks the new one, which is reported as dropped.
   always_ff @(posedge com_clk) begin
      if (reset) begin
         hit          <= 1'b0;
         hit_query_id <= '0;
         hit_sub_id   <= '0;
         hit_drop     <= 1'b0;
      end else begin
         hit_drop <= 1'b0;
         if (new_hit) begin
            if (hit && !hit_ack) begin
               hit_drop <= 1'b1;
            end else begin
               hit          <= 1'b1;
               hit_query_id <= query_id;
               hit_sub_id   <= hit_sid_calc;
            end
         end else if (hit && hit_ack) begin
            hit <= 1'b0;
         end
      end
   end
`else
   logic unused_hit_ack;
   assign unused_hit_ack = hit_ack;

   always_ff @(posedge com_clk) begin
      if (reset) begin
         hit          <= 1'b0;
         hit_query_id <= '0;
         hit_sub_id   <= '0;
         hit_drop     <= 1'b0;
      end else begin
         hit      <= new_hit;
         hit_drop <= 1'b0;
         if (new_hit) begin
            hit_query_id <= query_id;
            hit_sub_id   <= hit_sid_calc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_array_seed_cell.sv
// Bench for array_seed_cell: directed seed scenarios plus randomized traffic, all outputs compared
// every cycle against a count-based reference model.
`timescale 1ns/1ps

module tb_array_seed_cell;

  localparam int LENGTH_CHAR    = 3;
  localparam int LENGTH_COUNTER = 8;
  localparam int WORD_LEN       = 4;
  localparam int RUN_W          = 4;
  localparam int ID_MOD         = 1 << LENGTH_COUNTER;
  localparam int RUN_MAX        = (1 << RUN_W) - 1;

  localparam int A = 1, G = 2, T = 3, C = 4, N = 5;

  logic                      com_clk;
  logic                      reset;
  logic                      query_enable;
  logic [LENGTH_CHAR-1:0]    query_char_in;
  logic                      sub_enable;
  logic [LENGTH_CHAR-1:0]    sub_char_in;
  logic                      hit_ack;
  logic [LENGTH_CHAR-1:0]    query_char_out;
  logic [LENGTH_COUNTER-1:0] query_id;
  logic [LENGTH_CHAR-1:0]    sub_char_out;
  logic                      sub_valid_out;
  logic [LENGTH_COUNTER-1:0] sub_id;
  logic                      match;
  logic [RUN_W-1:0]          run_len;
  logic                      hit;
  logic [LENGTH_COUNTER-1:0] hit_query_id;
  logic [LENGTH_COUNTER-1:0] hit_sub_id;
  logic                      hit_drop;

  array_seed_cell #(
    .LENGTH_CHAR(LENGTH_CHAR), .LENGTH_COUNTER(LENGTH_COUNTER),
    .WORD_LEN(WORD_LEN), .RUN_W(RUN_W)
  ) dut (
    .com_clk(com_clk), .reset(reset),
    .query_enable(query_enable), .query_char_in(query_char_in),
    .sub_enable(sub_enable), .sub_char_in(sub_char_in),
    .hit_ack(hit_ack),
    .query_char_out(query_char_out), .query_id(query_id),
    .sub_char_out(sub_char_out), .sub_valid_out(sub_valid_out), .sub_id(sub_id),
    .match(match), .run_len(run_len),
    .hit(hit), .hit_query_id(hit_query_id), .hit_sub_id(hit_sub_id),
    .hit_drop(hit_drop)
  );

  // clock / reset
  initial com_clk = 1'b0;
  always #5 com_clk = ~com_clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: expected {hit_query_id, hit_sub_id} records for pulse-mode hits
  logic [2*LENGTH_COUNTER-1:0] exp_q[$];

  // reference model state: counts of accepted characters and an unbounded run length
  int m_qchar, m_schar, m_qcount, m_scount, m_run;
  bit m_sub_valid, m_match, m_hit, m_drop;
  int m_hit_qid, m_hit_sid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int id_of(input int count);
    return (count == 0) ? 0 : (count - 1) % ID_MOD;
  endfunction

  task automatic model_reset();
    m_qchar = 0; m_schar = 0; m_qcount = 0; m_scount = 0; m_run = 0;
    m_sub_valid = 0; m_match = 0; m_hit = 0; m_drop = 0;
    m_hit_qid = 0; m_hit_sid = 0;
    exp_q.delete();
  endtask

  task automatic model_cycle(input bit qe, input int qc, input bit se, input int sc, input bit ack);
    bit qacc, sacc, newhit;
    int nqid, nsid;
    qacc   = qe && (qc >= 1) && (qc <= 4);
    sacc   = se && (sc >= 1) && (sc <= 5);
    m_match = sacc && (sc != N) && (m_qchar != 0) && (sc == m_qchar);
    m_sub_valid = sacc;
    newhit = 0;
    nqid   = id_of(m_qcount);
    if (sacc) begin
      m_schar = sc;
      m_scount++;
    end
    if (qacc) m_run = 0;
    else if (sacc) begin
      if (m_match) begin
        m_run++;
        if (m_run == WORD_LEN) newhit = 1;
      end else m_run = 0;
    end
    if (qacc) begin
      m_qchar = qc;
      m_qcount++;
    end
    nsid = (id_of(m_scount) - (WORD_LEN - 1) + ID_MOD) % ID_MOD;
`ifdef ARRAY_HIT_HOLD_EN
    m_drop = 0;
    if (newhit) begin
      if (m_hit && !ack) m_drop = 1;
      else begin
        m_hit = 1; m_hit_qid = nqid; m_hit_sid = nsid;
      end
    end else if (m_hit && ack) m_hit = 0;
`else
    m_drop = 0;
    m_hit  = newhit;
    if (newhit) begin
      m_hit_qid = nqid; m_hit_sid = nsid;
      exp_q.push_back({LENGTH_COUNTER'(nqid), LENGTH_COUNTER'(nsid)});
    end
`endif
  endtask

  task automatic check_outputs();
    logic [2*LENGTH_COUNTER-1:0] rec;
    check_eq("query_char_out", query_char_out, m_qchar);
    check_eq("query_id", query_id, id_of(m_qcount));
    check_eq("sub_char_out", sub_char_out, m_schar);
    check_eq("sub_valid_out", sub_valid_out, m_sub_valid);
    check_eq("sub_id", sub_id, id_of(m_scount));
    check_eq("match", match, m_match);
    check_eq("run_len", run_len, (m_run > RUN_MAX) ? RUN_MAX : m_run);
    check_eq("hit", hit, m_hit);
    check_eq("hit_drop", hit_drop, m_drop);
    if (m_hit) begin
      check_eq("hit_query_id", hit_query_id, m_hit_qid);
      check_eq("hit_sub_id", hit_sub_id, m_hit_sid);
    end
`ifndef ARRAY_HIT_HOLD_EN
    if (hit === 1'b1) begin
      if (exp_q.size() == 0) check_eq("hit_unexpected", 1, 0);
      else begin
        rec = exp_q.pop_front();
        check_eq("sb_hit_ids", {hit_query_id, hit_sub_id}, rec);
      end
    end
`endif
  endtask

  // driver: inputs change 1 time unit after the edge, outputs sampled 1 unit after the next edge
  task automatic step(input bit rst, input bit qe, input int qc, input bit se, input int sc,
                      input bit ack);
    reset = rst;
    query_enable = qe; query_char_in = LENGTH_CHAR'(qc);
    sub_enable = se;   sub_char_in = LENGTH_CHAR'(sc);
    hit_ack = ack;
    @(posedge com_clk);
    if (rst) model_reset();
    else model_cycle(qe, qc, se, sc, ack);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic sub(input int c);   step(0, 0, 0, 1, c, 0); endtask
  task automatic qry(input int c);   step(0, 1, c, 0, 0, 0); endtask
  task automatic idle(input bit ack); step(0, 0, 0, 0, 0, ack); endtask

  initial begin
    int qc, sc;
    model_reset();
    reset = 1; query_enable = 0; query_char_in = '0;
    sub_enable = 0; sub_char_in = '0; hit_ack = 0;
    #1;
    do_reset();

    // subjects with no query loaded
    sub(A); sub(G); sub(T);
    check_eq("empty_sub_id", sub_id, 2);

    // five matching A's: single hit at run 4
    do_reset();
    qry(A);
    for (int i = 0; i < 4; i++) sub(A);
    check_eq("seed_a_hit", hit, 1);
    check_eq("seed_a_hit_sid", hit_sub_id, 0);
    sub(A);
    check_eq("seed_a_run5", run_len, 5);

    // N breaks the run
    do_reset();
    qry(G);
    sub(G); sub(G); sub(N); sub(G); sub(G); sub(G); sub(G);
    check_eq("seed_g_hit_sid", hit_sub_id, 3);

    // query reload coincident with a matching subject
    do_reset();
    qry(C); sub(C); sub(C); sub(C);
    step(0, 1, C, 1, C, 0);
    check_eq("reload_match", match, 1);
    check_eq("reload_run", run_len, 0);
    check_eq("reload_hit", hit, 0);
    sub(C);

    // invalid codes are ignored on both streams
    qry(0); qry(5); qry(7); sub(0); sub(6); sub(7);

    // subject ids wrapping through all-ones
    do_reset();
    qry(A);
    for (int i = 0; i < 254; i++) sub(T);
    for (int i = 0; i < 4; i++) sub(A);
    check_eq("wrap_hit_sid", hit_sub_id, 254);

    // run counter saturation
    do_reset();
    qry(A);
    for (int i = 0; i < 18; i++) sub(A);

    // held hit, then a second hit before acknowledge, then acknowledge
    do_reset();
    qry(T);
    for (int i = 0; i < 4; i++) sub(T);
    for (int i = 0; i < 5; i++) idle(0);
    sub(N);
    for (int i = 0; i < 4; i++) sub(T);
    idle(1); idle(0);
    sub(G);
    for (int i = 0; i < 3; i++) sub(T);
    step(0, 0, 0, 1, T, 1);
    idle(1); idle(0);

    // reset in the middle of a run with a hit outstanding
    qry(G); sub(G); sub(G); sub(G); sub(G);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1, 0, 0, 0, 0, 0);
      end else begin
        qc = $urandom_range(0, 7);
        if ((m_qchar != 0) && ($urandom_range(0, 9) < 7)) sc = m_qchar;
        else sc = $urandom_range(0, 7);
        step(0, ($urandom_range(0, 15) == 0), qc, ($urandom_range(0, 3) != 0), sc,
             ($urandom_range(0, 3) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
